// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and defaults for the hazard detection unit
// Contents: MUL sequencer state enum, MUL_LAT/REG_W defaults, counter width.
package hazard_pkg;
  typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_RELEASE} mul_state_t;
  localparam int MUL_LAT_DEF = 3;
  localparam int REG_W_DEF = 5;
  localparam int CNT_W = 3;
endpackage

// File: rtl/hazard_detect_unit_if.sv
// hazard_detect_unit_if: pipeline <-> hazard unit signal bundle
// master: pipeline side, drives register/flag info, receives enables and flushes.
// slave:  hazard unit side.
interface hazard_detect_unit_if #(parameter int REG_W = hazard_pkg::REG_W_DEF);
  logic [REG_W-1:0] rs1_IF_ID, rs2_IF_ID, rd_ID_EX;
  logic use_rs1_IF_ID, use_rs2_IF_ID, mem_read_ID_EX, is_mul_ID_EX, branch_taken_EX;
  logic pc_write_en, if_id_write_en, id_ex_write_en;
  logic if_id_flush, id_ex_flush, ex_mem_bubble;
  modport master (
    output rs1_IF_ID, rs2_IF_ID, rd_ID_EX, use_rs1_IF_ID, use_rs2_IF_ID,
           mem_read_ID_EX, is_mul_ID_EX, branch_taken_EX,
    input  pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_flush, ex_mem_bubble
  );
  modport slave (
    input  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, use_rs1_IF_ID, use_rs2_IF_ID,
           mem_read_ID_EX, is_mul_ID_EX, branch_taken_EX,
    output pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_flush, ex_mem_bubble
  );
endinterface

// File: rtl/mul_stall_seq.sv
// mul_stall_seq: multi-cycle MUL sequencer holding the pipeline while a MUL occupies EX
// Ports: clk, arst (async active-high), is_mul (MUL in EX), stall (hold pipeline),
//        idle (sequencer in IDLE; gates load-use detection).
module mul_stall_seq import hazard_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic is_mul,
  output logic stall,
  output logic idle
);
  mul_state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // The IDLE cycle that sees the MUL already stalls, so BUSY covers MUL_LAT-2 more
  // cycles and RELEASE lets the MUL move on: MUL_LAT-1 stall cycles in total.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stall = 1'b0;
    case (state)
      IDLE:
        if (is_mul) begin
          stall = 1'b1;
          cnt_nx = CNT_W'(MUL_LAT - 2);
          state_nx = (MUL_LAT == 2) ? MUL_RELEASE : MUL_BUSY;
        end
      MUL_BUSY: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) state_nx = MUL_RELEASE;
        else cnt_nx = cnt - CNT_W'(1);
      end
      MUL_RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign idle = (state == IDLE);
endmodule

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use / multi-cycle MUL / taken-branch hazard control
// Ports: clk, arst (async active-high), bus (hazard_detect_unit_if.slave),
//        stall_cycles (32-bit stall counter, only with HAZARD_STALL_CNT_EN defined).
// Priority: taken branch > MUL stall > load-use.
module hazard_detect_unit import hazard_pkg::*; #(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic clk,
  input  logic arst,
  hazard_detect_unit_if.slave bus
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  logic mul_stall, idle, load_use;
  logic [REG_W-1:0] rd;
  mul_stall_seq #(.MUL_LAT(MUL_LAT)) u_seq (
    .clk(clk),
    .arst(arst),
    .is_mul(bus.is_mul_ID_EX),
    .stall(mul_stall),
    .idle(idle)
  );
  assign rd = bus.rd_ID_EX;
  // x0 never carries a real dependency, and a MUL in flight already holds the pipe.
  assign load_use = idle && bus.mem_read_ID_EX && (rd != '0) &&
                    ((bus.use_rs1_IF_ID && bus.rs1_IF_ID == rd) ||
                     (bus.use_rs2_IF_ID && bus.rs2_IF_ID == rd));
  always_comb begin
    bus.pc_write_en = 1'b1;
    bus.if_id_write_en = 1'b1;
    bus.id_ex_write_en = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.ex_mem_bubble = 1'b0;
    if (arst) begin
      bus.pc_write_en = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.id_ex_write_en = 1'b0;
    end else if (bus.branch_taken_EX) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (mul_stall) begin
      bus.pc_write_en = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.id_ex_write_en = 1'b0;
      bus.ex_mem_bubble = 1'b1;
    end else if (load_use) begin
      bus.pc_write_en = 1'b0;
      bus.if_id_write_en = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
  end
`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge arst)
    if (arst) stall_cycles <= '0;
    else if (!bus.pc_write_en) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: randomized + directed check of hazard_detect_unit (MUL_LAT=3 and 2)
module tb_hazard_detect_unit;
  logic clk = 1'b0;
  logic arst = 1'b1;
  int total = 0;
  int bad = 0;
  int busy3 = 0;
  int busy2 = 0;
  logic [31:0] sc3 = '0;
  always #5 clk = ~clk;

  hazard_detect_unit_if #(.REG_W(5)) i3 ();
  hazard_detect_unit_if #(.REG_W(5)) i2 ();
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] sc_o3, sc_o2;
`endif

  hazard_detect_unit #(.MUL_LAT(3), .REG_W(5)) u3 (
    .clk(clk), .arst(arst), .bus(i3.slave)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(sc_o3)
`endif
  );
  hazard_detect_unit #(.MUL_LAT(2), .REG_W(5)) u2 (
    .clk(clk), .arst(arst), .bus(i2.slave)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(sc_o2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // busy = cycles the current MUL still holds EX, counting the present cycle (0 = idle)
  // result bits: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_bubble}
  function automatic logic [5:0] model(int busy, logic [4:0] rs1, rs2, rd,
                                       logic u1, u2, mr, mul, br, rst);
    logic stall, lu;
    stall = (busy == 0 && mul) || busy >= 2;
    lu = busy == 0 && mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (rst) return 6'b000000;
    if (br) return 6'b111110;
    if (stall) return 6'b000001;
    if (lu) return 6'b001010;
    return 6'b111000;
  endfunction

  function automatic int nxt(int busy, int lat, logic mul, logic rst);
    if (rst) return 0;
    if (busy == 0) return mul ? lat - 1 : 0;
    return busy - 1;
  endfunction

  task automatic step(input logic [4:0] rs1, rs2, rd,
                      input logic u1, u2, mr, mul, br, rst);
    logic [5:0] e3, e2;
    @(negedge clk);
    i3.rs1_IF_ID = rs1; i3.rs2_IF_ID = rs2; i3.rd_ID_EX = rd;
    i3.use_rs1_IF_ID = u1; i3.use_rs2_IF_ID = u2; i3.mem_read_ID_EX = mr;
    i3.is_mul_ID_EX = mul; i3.branch_taken_EX = br;
    i2.rs1_IF_ID = rs1; i2.rs2_IF_ID = rs2; i2.rd_ID_EX = rd;
    i2.use_rs1_IF_ID = u1; i2.use_rs2_IF_ID = u2; i2.mem_read_ID_EX = mr;
    i2.is_mul_ID_EX = mul; i2.branch_taken_EX = br;
    arst = rst;
    #1;
    e3 = model(busy3, rs1, rs2, rd, u1, u2, mr, mul, br, rst);
    e2 = model(busy2, rs1, rs2, rd, u1, u2, mr, mul, br, rst);
    chk("out_lat3", {26'd0, i3.pc_write_en, i3.if_id_write_en, i3.id_ex_write_en,
                     i3.if_id_flush, i3.id_ex_flush, i3.ex_mem_bubble}, {26'd0, e3});
    chk("out_lat2", {26'd0, i2.pc_write_en, i2.if_id_write_en, i2.id_ex_write_en,
                     i2.if_id_flush, i2.id_ex_flush, i2.ex_mem_bubble}, {26'd0, e2});
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt", sc_o3, rst ? 32'd0 : sc3);
`endif
    @(posedge clk);
    busy3 = nxt(busy3, 3, mul, rst);
    busy2 = nxt(busy2, 2, mul, rst);
    sc3 = rst ? 32'd0 : sc3 + {31'd0, ~e3[5]};
  endtask

  task automatic idle_step();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
    step(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) idle_step();
    step(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_step();
    idle_step();
    step(5'd2, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
`ifdef HAZARD_STALL_CNT_EN
    #1 chk("stall_cnt_mul_lu", sc_o3, 32'd3);
`endif
    repeat (3000)
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 39) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_detect_unit.md
HAZARD_DETECT_UNIT -- requirements
Module: hazard_detect_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, range 2..8, meaning total cycles a MUL occupies EX.
REQ-002 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-003 SHALL have ports clk, input, 1 bit, the single clock; one clock domain only.
REQ-004 SHALL have ports arst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have ports rs1_IF_ID / rs2_IF_ID, input, REG_W each, source registers of the instruction in ID.
REQ-006 SHALL have ports use_rs1_IF_ID / use_rs2_IF_ID, input, 1 each, source actually read.
REQ-007 SHALL have ports rd_ID_EX, mem_read_ID_EX and is_mul_ID_EX, inputs, REG_W/1/1; these are the destination, load flag and MUL flag of the instruction in EX.
REQ-008 SHALL have port branch_taken_EX, input, 1 bit, taken branch or jump resolved in EX.
REQ-009 SHALL have outputs pc_write_en, if_id_write_en, id_ex_write_en (1 each), 1 = register updates.
REQ-010 SHALL have outputs if_id_flush, id_ex_flush, ex_mem_bubble (1 each), 1 = zero the control bits of that pipeline register at the next edge.

Function
REQ-011 SHALL detect load-use when mem_read_ID_EX=1, rd_ID_EX!=0 and rd_ID_EX matches an rs*_IF_ID whose use_rs* is 1.
- Response, same cycle: pc_write_en=0, if_id_write_en=0, id_ex_flush=1.
- Exactly one bubble per load-use.
REQ-012 SHALL use an FSM with states IDLE, MUL_BUSY and MUL_RELEASE, plus a 3-bit down-counter cnt.
REQ-013 SHALL leave IDLE when is_mul_ID_EX=1 in IDLE.
- Stall is asserted that same cycle.
- cnt loads MUL_LAT-2.
- Next state is MUL_BUSY, or MUL_RELEASE if MUL_LAT=2.
REQ-014 SHALL assert stall in MUL_BUSY every cycle.
- If cnt=1: next state is MUL_RELEASE.
- Otherwise: cnt decrements.
REQ-015 SHALL treat MUL_RELEASE as a no-stall cycle: the MUL advances to MEM and the next state is IDLE.
- is_mul_ID_EX is ignored in MUL_RELEASE; there is no retrigger.
REQ-016 SHALL drive the MUL stall as pc_write_en=0, if_id_write_en=0, id_ex_write_en=0 and ex_mem_bubble=1.
- Net effect: exactly MUL_LAT-1 stall cycles per MUL.
REQ-017 SHALL apply priority branch_taken_EX > MUL stall > load-use.
- On branch: if_id_flush=1, id_ex_flush=1, pc_write_en=1 and no stall.
REQ-018 SHALL, for back-to-back MULs, detect the second MUL only when it reaches ID/EX after the first one's MUL_RELEASE; each MUL stalls MUL_LAT-1 cycles.
REQ-019 SHALL suppress load-use detection while the state is not IDLE.
REQ-020 SHALL otherwise drive all write enables to 1 and all flush/bubble outputs to 0.

Reset
REQ-021 SHALL, while arst=1, hold state=IDLE and cnt=0.
- Outputs during reset: pc_write_en=if_id_write_en=id_ex_write_en=0 and all flush/bubble=0.
REQ-022 SHALL abort any MUL sequence when arst is asserted mid-sequence.
- The first cycle after release is evaluated from IDLE.

Configuration
REQ-023 SHALL, with macro HAZARD_STALL_CNT_EN defined, add output stall_cycles (32 bits).
- Increments on every cycle with pc_write_en=0 and arst=0.
- Wraps at 2^32-1 to 0; resets to 0.
REQ-024 SHALL, without HAZARD_STALL_CNT_EN, have no stall_cycles port and no counter logic.

Structure
REQ-025 SHALL place the FSM state enum (IDLE/MUL_BUSY/MUL_RELEASE), the MUL_LAT default and REG_W default in shared package hazard_pkg.
REQ-026 SHALL implement the MUL sequencer (FSM plus cnt) as sub-module mul_stall_seq.
- Top level holds the load-use compare, priority mux and optional stall counter.

Verification
REQ-027 Load-use: rd_ID_EX=5, mem_read=1, rs1_IF_ID=5, use_rs1=1 -> one cycle of pc_write_en=0 and id_ex_flush=1, then normal.
REQ-028 Load to x0: rd_ID_EX=0, mem_read=1, rs2_IF_ID=0, use_rs2=1 -> no stall.
REQ-029 MUL with MUL_LAT=3: is_mul_ID_EX=1 held -> 2 stall cycles (ex_mem_bubble=1), third cycle MUL_RELEASE with no stall, then IDLE; with MUL_LAT=2 -> 1 stall cycle.
REQ-030 Simultaneous: branch_taken_EX=1 plus load-use match -> if_id_flush=id_ex_flush=1, pc_write_en=1, no stall.
REQ-031 Reset mid-MUL: arst pulsed in MUL_BUSY -> outputs at reset values; after release with is_mul_ID_EX=0 -> state IDLE, all enables 1.
REQ-032 With HAZARD_STALL_CNT_EN: one MUL (MUL_LAT=3) plus one load-use -> stall_cycles=3.
